trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Multi-cycle controller for the RV32I-Trap datapath.
- Accepts synchronous exceptions and level interrupts, then sequences the load-enables of the trap CSR registers (mepc, mcause, mtval) and stalls the core while it works.
- Redirects the PC to the trap vector, and handles mret.
- Owns the global interrupt-enable state (MIE/MPIE); the CSR registers themselves are plain load-enable registers outside this block.

Parameters:
- XLEN, 32, datapath/CSR width.
- NUM_IRQ, 4, number of interrupt lines; index 0 has the highest priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- exc_valid  in  1  synchronous exception from the current instruction.
- exc_code  in  4  exception cause code.
- exc_tval  in  XLEN  faulting address or instruction.
- irq_pending  in  NUM_IRQ  level interrupt requests.
- mret  in  1  current instruction is mret.
- pc_cur  in  XLEN  PC of the current instruction.
- mtvec  in  XLEN  trap vector register value; [1:0]==01 selects vectored mode.
- mepc_q  in  XLEN  current mepc register value.
- csr_mie_we  in  1  software write of mstatus.MIE.
- csr_mie_d  in  1  value for that write.
- stall  out  1  freeze the fetch/execute pipeline.
- mepc_ld  out  1  load enable for mepc.
- mepc_d  out  XLEN  data for mepc.
- mtval_ld  out  1  load enable for mtval.
- mtval_d  out  XLEN  data for mtval.
- mcause_ld  out  1  load enable for mcause.
- mcause_d  out  XLEN  data for mcause.
- pc_redirect  out  1  one-cycle PC load strobe.
- pc_target  out  XLEN  new PC value.
- mie  out  1  global interrupt enable.
- mpie  out  1  previous interrupt enable.

Behaviour:
- States: IDLE, SAVE, CAUSE, JUMP, RET. On reset: state=IDLE, mie=0, mpie=0, all latches=0, all outputs 0.
- IDLE accept rule, evaluated each cycle, highest priority first:
  - exc_valid=1 -> exception trap.
  - else mie=1 and any irq_pending bit set -> interrupt trap; lowest set index wins.
  - else mret=1 -> RET.
  - Trap beats mret when both occur in the same cycle.
- On trap acceptance, in the same edge:
  - Latch pc_cur, cause and tval. Exception tval = exc_tval; interrupt tval = 0.
  - Cause word: bit XLEN-1 = 1 for interrupts; low bits = exc_code, or 16+irq index for interrupts.
  - Go to SAVE.
- SAVE: mepc_ld=1, mepc_d=latched pc; mtval_ld=1, mtval_d=latched tval. Next state CAUSE.
- CAUSE: mcause_ld=1, mcause_d=latched cause; on exit mpie<=mie and mie<=0. Next state JUMP.
- JUMP: pc_redirect=1.
  - pc_target = {mtvec[XLEN-1:2],2'b00}.
  - In vectored mode, interrupt traps add 4*(low cause bits).
  - Next state IDLE.
- RET: pc_redirect=1, pc_target=mepc_q; on exit mie<=mpie and mpie<=1. Next state IDLE.
- stall=1 in every state except IDLE.
- All strobes are single-cycle, Moore-decoded from state.
- Latency:
  - Trap: accept at edge 0, then SAVE, CAUSE, JUMP in cycles 1-3; a new trap can be accepted in cycle 4.
  - mret: one stall cycle.
- While not IDLE, all request inputs are ignored. Interrupts are level-sensitive, so they must still be asserted when IDLE resamples them.
- csr_mie_we is honoured only in IDLE and when no trap is accepted in that cycle. In CAUSE and RET the FSM update wins.
- Reset mid-sequence returns to IDLE immediately. No partial strobes are emitted after rst deasserts.
- Exceptions are taken regardless of mie.

Test Plan:
- Reset, then exc_valid=1, exc_code=2, pc_cur=0x100, exc_tval=0xDEAD, mtvec=0x200 -> mepc_ld cycle 1 (mepc_d=0x100, mtval_d=0xDEAD); mcause_ld cycle 2 (mcause_d=2); pc_redirect cycle 3 (pc_target=0x200); stall=1 in cycles 1-3.
- csr_mie_we=1/d=1, then irq_pending=4'b0110 with mtvec=0x301 -> mcause_d=0x80000011; pc_target=0x344; mie=0 and mpie=1 after CAUSE.
- irq_pending=4'b0001 with mie=0 -> no stall and no strobes for 10 cycles.
- After the trap above, mret=1 with mepc_q=0x104 -> one stall cycle; pc_redirect with pc_target=0x104; mie=1, mpie=1.
- exc_valid=1 and mret=1 in the same cycle -> trap sequence taken, RET never entered.
- Assert rst during CAUSE -> state IDLE, mie=0, no pc_redirect; next exception completes the full 3-cycle sequence.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap sequencer for the RV32I-Trap datapath.
// Takes synchronous exceptions and level interrupts and steps the trap CSR
// load-enables through SAVE -> CAUSE -> JUMP, stalling the core meanwhile.
// It also performs the mret return and owns the MIE/MPIE global enable bits.
module trap_sequencer #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic               mret,
  input  logic [XLEN-1:0]    pc_cur,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_q,
  input  logic               csr_mie_we,
  input  logic               csr_mie_d,
  output logic               stall,
  output logic               mepc_ld,
  output logic [XLEN-1:0]    mepc_d,
  output logic               mtval_ld,
  output logic [XLEN-1:0]    mtval_d,
  output logic               mcause_ld,
  output logic [XLEN-1:0]    mcause_d,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    pc_target,
  output logic               mie,
  output logic               mpie
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {IDLE, SAVE, CAUSE, JUMP, RET} state_t;

  state_t            state_q, state_d;
  logic              mie_q, mpie_q;
  logic [XLEN-1:0]   pc_lat, cause_lat, tval_lat;
  logic              irq_any;
  logic [IDX_W-1:0]  irq_idx;
  logic              take_exc, take_irq, take_trap, take_ret;
  logic [XLEN-1:0]   cause_new, tval_new;

  // Exception cause: interrupt flag clear, code in the low bits.
  function automatic logic [XLEN-1:0] exc_cause(input logic [3:0] code);
    logic [XLEN-1:0] c;
    c = '0;
    c[3:0] = code;
    return c;
  endfunction

  // Interrupt cause: interrupt flag set, 16 + line index in the low bits.
  function automatic logic [XLEN-1:0] irq_cause(input logic [IDX_W-1:0] idx);
    logic [XLEN-1:0] c;
    c = '0;
    c[XLEN-1]   = 1'b1;
    c[XLEN-2:0] = (XLEN-1)'(16) + (XLEN-1)'(idx);
    return c;
  endfunction

  // Trap entry address: aligned base, plus 4*cause for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_vector(input logic [XLEN-1:0] tvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] t;
    t = {tvec[XLEN-1:2], 2'b00};
    if (tvec[1:0] == 2'b01 && cause[XLEN-1])
      t = t + {cause[XLEN-3:0], 2'b00};
    return t;
  endfunction

  // Priority encoder: the lowest pending interrupt index wins.
  always_comb begin
    irq_idx = '0;
    irq_any = |irq_pending;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_pending[i]) irq_idx = IDX_W'(i);
  end

  // Request arbitration in IDLE: exception, then enabled interrupt, then mret.
  always_comb begin
    take_exc  = (state_q == IDLE) && exc_valid;
    take_irq  = (state_q == IDLE) && !exc_valid && mie_q && irq_any;
    take_trap = take_exc || take_irq;
    take_ret  = (state_q == IDLE) && !take_trap && mret;
    cause_new = take_exc ? exc_cause(exc_code) : irq_cause(irq_idx);
    tval_new  = take_exc ? exc_tval : '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_trap)     state_d = SAVE;
               else if (take_ret) state_d = RET;
      SAVE:    state_d = CAUSE;
      CAUSE:   state_d = JUMP;
      JUMP:    state_d = IDLE;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture PC, cause and tval on trap acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_lat    <= '0;
      cause_lat <= '0;
      tval_lat  <= '0;
    end else if (take_trap) begin
      pc_lat    <= pc_cur;
      cause_lat <= cause_new;
      tval_lat  <= tval_new;
    end
  end

  // MIE/MPIE: sequencer stack/unstack in CAUSE and RET, software write in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else begin
      case (state_q)
        CAUSE: begin
          mpie_q <= mie_q;
          mie_q  <= 1'b0;
        end
        RET: begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end
        IDLE: if (csr_mie_we && !take_trap) mie_q <= csr_mie_d;
        default: ;
      endcase
    end
  end

  // Moore output decode: one strobe group per state, data zero elsewhere.
  always_comb begin
    stall       = (state_q != IDLE);
    mepc_ld     = 1'b0;
    mepc_d      = '0;
    mtval_ld    = 1'b0;
    mtval_d     = '0;
    mcause_ld   = 1'b0;
    mcause_d    = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    case (state_q)
      SAVE: begin
        mepc_ld  = 1'b1;
        mepc_d   = pc_lat;
        mtval_ld = 1'b1;
        mtval_d  = tval_lat;
      end
      CAUSE: begin
        mcause_ld = 1'b1;
        mcause_d  = cause_lat;
      end
      JUMP: begin
        pc_redirect = 1'b1;
        pc_target   = trap_vector(mtvec, cause_lat);
      end
      RET: begin
        pc_redirect = 1'b1;
        pc_target   = mepc_q;
      end
      default: ;
    endcase
  end

  assign mie  = mie_q;
  assign mpie = mpie_q;

endmodule
